// File: rtl/irq_pkg.sv
// ----------------------------------------------------------------------------
// irq_pkg: register map and channel state encoding for irq_conditioner.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package irq_pkg;

    localparam logic [1:0] IRQ_ADDR_ENABLE   = 2'd0;
    localparam logic [1:0] IRQ_ADDR_PENDING  = 2'd1;
    localparam logic [1:0] IRQ_ADDR_OVERFLOW = 2'd2;
    localparam logic [1:0] IRQ_ADDR_POLARITY = 2'd3;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PULSE = 2'd1,
        IRQ_GAP   = 2'd2
    } irq_state_t;

    function automatic int irq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_channel.sv
// ----------------------------------------------------------------------------
// irq_channel: synchroniser, edge detect, pulse FSM, pending/overflow for one IRQ.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_channel
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic enable,
    input  logic polarity,
    input  logic enable_clr,
    input  logic pending_w1c,
    input  logic overflow_w1c,
    output logic irq_out,
    output logic pending,
    output logic overflow
);

    localparam int CW = $clog2(irq_max(PULSE_LEN, GAP_LEN)) + 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES:0]   r_fill;
    logic                   r_prev;
    irq_state_t             r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_irq_out;
    logic                   r_pending;
    logic                   r_overflow;

    logic w_s;
    logic w_edge;
    logic w_event;
    logic w_busy;
    logic w_cnt_zero;
    logic w_consume;
    logic w_queue;
    logic w_ovf;

    assign w_s        = r_sync[SYNC_STAGES-1];
    // Edges are ignored until the chain and delayed copy hold real samples,
    // so a source already high at reset release does not fire.
    assign w_edge     = r_fill[SYNC_STAGES] &
                        (polarity ? (r_prev & ~w_s) : (w_s & ~r_prev));
    assign w_event    = w_edge & enable;
    assign w_busy     = (r_state != IRQ_IDLE);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_consume  = (r_state == IRQ_GAP) && w_cnt_zero && r_pending;
    assign w_queue    = w_event && w_busy && (!r_pending || w_consume);
    assign w_ovf      = w_event && w_busy && r_pending && !w_consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '0;
            r_fill     <= '0;
            r_prev     <= 1'b0;
            r_state    <= IRQ_IDLE;
            r_cnt      <= '0;
            r_irq_out  <= 1'b0;
            r_pending  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], irq_in};
            r_fill    <= {r_fill[SYNC_STAGES-1:0], 1'b1};
            r_prev    <= w_s;
            r_irq_out <= (r_state == IRQ_PULSE);

            case (r_state)
                IRQ_IDLE: begin
                    if (w_event) begin
                        r_state <= IRQ_PULSE;
                        r_cnt   <= PULSE_LOAD;
                    end
                end
                IRQ_PULSE: begin
                    if (w_cnt_zero) begin
                        r_state <= IRQ_GAP;
                        r_cnt   <= GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                IRQ_GAP: begin
                    if (w_cnt_zero) begin
                        if (w_consume) begin
                            r_state <= IRQ_PULSE;
                            r_cnt   <= PULSE_LOAD;
                        end else begin
                            r_state <= IRQ_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= IRQ_IDLE;
            endcase

            if (enable_clr || !enable)
                r_pending <= 1'b0;
            else if (w_queue)
                r_pending <= 1'b1;
            else if (w_consume || pending_w1c)
                r_pending <= 1'b0;

            if (w_ovf)
                r_overflow <= 1'b1;
            else if (overflow_w1c)
                r_overflow <= 1'b0;
        end
    end

    assign irq_out  = r_irq_out;
    assign pending  = r_pending;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/irq_conditioner.sv
// ----------------------------------------------------------------------------
// irq_conditioner: NUM_IRQ conditioned interrupt channels plus control registers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_conditioner
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 4,
    parameter int GAP_LEN     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [NUM_IRQ-1:0] irq_out,
    input  logic [1:0]         cfg_addr,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_d,
    output logic [NUM_IRQ-1:0] cfg_q
);

    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_polarity;
    logic [NUM_IRQ-1:0] r_cfg_q;

    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_overflow;
    logic [NUM_IRQ-1:0] w_enable_clr;
    logic [NUM_IRQ-1:0] w_pending_w1c;
    logic [NUM_IRQ-1:0] w_overflow_w1c;
    logic [NUM_IRQ-1:0] w_rdata;

    assign w_enable_clr   = (cfg_we && cfg_addr == IRQ_ADDR_ENABLE)   ? ~cfg_d : '0;
    assign w_pending_w1c  = (cfg_we && cfg_addr == IRQ_ADDR_PENDING)  ? cfg_d  : '0;
    assign w_overflow_w1c = (cfg_we && cfg_addr == IRQ_ADDR_OVERFLOW) ? cfg_d  : '0;

    generate
        for (genvar i = 0; i < NUM_IRQ; i++) begin : g_chan
            irq_channel #(
                .SYNC_STAGES (SYNC_STAGES),
                .PULSE_LEN   (PULSE_LEN),
                .GAP_LEN     (GAP_LEN)
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .irq_in       (irq_in[i]),
                .enable       (r_enable[i]),
                .polarity     (r_polarity[i]),
                .enable_clr   (w_enable_clr[i]),
                .pending_w1c  (w_pending_w1c[i]),
                .overflow_w1c (w_overflow_w1c[i]),
                .irq_out      (irq_out[i]),
                .pending      (w_pending[i]),
                .overflow     (w_overflow[i])
            );
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (cfg_addr)
            IRQ_ADDR_ENABLE:   w_rdata = r_enable;
            IRQ_ADDR_PENDING:  w_rdata = w_pending;
            IRQ_ADDR_OVERFLOW: w_rdata = w_overflow;
            IRQ_ADDR_POLARITY: w_rdata = r_polarity;
            default:           w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable   <= '1;
            r_polarity <= '0;
            r_cfg_q    <= '0;
        end else begin
            if (cfg_we && cfg_addr == IRQ_ADDR_ENABLE)
                r_enable <= cfg_d;
            if (cfg_we && cfg_addr == IRQ_ADDR_POLARITY)
                r_polarity <= cfg_d;
            r_cfg_q <= w_rdata;
        end
    end

    assign cfg_q = r_cfg_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_conditioner.sv
// ----------------------------------------------------------------------------
// tb_irq_conditioner: directed self-checking bench for irq_conditioner.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irq_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic [7:0] irq_out;
    logic [1:0] cfg_addr;
    logic       cfg_we;
    logic [7:0] cfg_d;
    logic [7:0] cfg_q;

    int errors = 0;
    int checks = 0;

    irq_conditioner dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .irq_out  (irq_out),
        .cfg_addr (cfg_addr),
        .cfg_we   (cfg_we),
        .cfg_d    (cfg_d),
        .cfg_q    (cfg_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] data);
        cfg_addr = addr;
        @(negedge clk);
        data = {24'h0, cfg_q};
    endtask

    task automatic wr(input logic [1:0] addr, input logic [7:0] data);
        cfg_addr = addr;
        cfg_d    = data;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Bit c of h is irq_out[ch] after the c-th rising edge following the call.
    task automatic capture(input int ch, input int n, output logic [31:0] h);
        h = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            h[c] = irq_out[ch];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] h;
        logic [31:0] v;
        logic [5:0]  pat;
        logic [7:0]  out_at_reset;

        reset    = 1'b1;
        irq_in   = '0;
        cfg_addr = '0;
        cfg_we   = 1'b0;
        cfg_d    = '0;
        pat      = 6'b010101;
        out_at_reset = '0;
        repeat (3) @(negedge clk);
        check("reset_irq_out", {24'h0, irq_out}, 32'h0);
        check("reset_cfg_q", {24'h0, cfg_q}, 32'h0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        rd(2'd0, v); check("reset_enable", v, 32'hFF);
        rd(2'd1, v); check("reset_pending", v, 32'h00);
        rd(2'd2, v); check("reset_overflow", v, 32'h00);
        rd(2'd3, v); check("reset_polarity", v, 32'h00);

        // Single event on channel 3: high for cycles 3..6 relative to the change
        irq_in[3] = 1'b1;
        capture(3, 12, h);
        check("single_pulse", h, 32'h078);
        rd(2'd1, v); check("single_pending", v, 32'h00);
        rd(2'd2, v); check("single_overflow", v, 32'h00);
        irq_in[3] = 1'b0;
        repeat (8) @(negedge clk);

        // Three events on channel 0: one pulse, one queued, one overflow
        h = '0;
        for (int c = 0; c < 20; c++) begin
            irq_in[0] = (c < 6) ? pat[c] : 1'b0;
            @(negedge clk);
            h[c] = irq_out[0];
        end
        check("queue_pulses", h, 32'h1E78);
        rd(2'd1, v); check("queue_pending", v, 32'h00);
        rd(2'd2, v); check("queue_overflow", v, 32'h01);

        // Overflow W1C in the same cycle as a fresh overflow event
        h = '0;
        for (int c = 0; c < 20; c++) begin
            irq_in[0] = (c < 6) ? pat[c] : 1'b0;
            if (c == 6) begin
                cfg_addr = 2'd2;
                cfg_d    = 8'h01;
                cfg_we   = 1'b1;
            end else begin
                cfg_we   = 1'b0;
            end
            @(negedge clk);
            h[c] = irq_out[0];
        end
        cfg_we = 1'b0;
        check("race_pulses", h, 32'h1E78);
        rd(2'd2, v); check("race_overflow", v, 32'h01);
        wr(2'd2, 8'h01);
        rd(2'd2, v); check("w1c_overflow", v, 32'h00);

        // Masking: disabled edge is dropped and not replayed on re-enable
        wr(2'd0, 8'hFE);
        irq_in[0] = 1'b1;
        capture(0, 10, h);
        check("mask_disabled", h, 32'h0);
        wr(2'd0, 8'hFF);
        capture(0, 10, h);
        check("mask_reenable", h, 32'h0);
        rd(2'd1, v); check("mask_pending", v, 32'h00);
        irq_in[0] = 1'b0;
        repeat (5) @(negedge clk);

        // Falling-edge polarity on channel 7
        wr(2'd3, 8'h80);
        irq_in[7] = 1'b1;
        capture(7, 10, h);
        check("pol_rise_ignored", h, 32'h0);
        irq_in[7] = 1'b0;
        capture(7, 12, h);
        check("pol_fall_pulse", h, 32'h078);
        rd(2'd3, v); check("pol_readback", v, 32'h80);

        // Reset in second pulse cycle on channel 5 with pending set; source stays high
        h = '0;
        for (int c = 0; c < 20; c++) begin
            irq_in[5] = (c == 0 || c >= 2);
            reset     = (c == 5);
            @(negedge clk);
            h[c] = irq_out[5];
            if (c == 5) out_at_reset = irq_out;
        end
        reset = 1'b0;
        check("rst_pulse_cut", h, 32'h18);
        check("rst_irq_out", {24'h0, out_at_reset}, 32'h0);
        rd(2'd0, v); check("rst_enable", v, 32'hFF);
        rd(2'd1, v); check("rst_pending", v, 32'h00);
        rd(2'd2, v); check("rst_overflow", v, 32'h00);
        rd(2'd3, v); check("rst_polarity", v, 32'h00);
        irq_in = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
